// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus responder.
package dbus_pkg;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // MMIO register offsets from MMIO_BASE, in bytes.
  localparam logic [31:0] GPIO_OFS = 32'h0000_0000;
  localparam logic [31:0] CNT_OFS  = 32'h0000_0004;

  // Result of decoding a byte address.
  typedef enum logic [1:0] {
    HIT_RAM,
    HIT_GPIO,
    HIT_CNT,
    MISS
  } hit_e;

endpackage

// File: rtl/dbus_ram_array.sv
// Word-wide data RAM: synchronous write, asynchronous read, no reset.
module dbus_ram_array #(
  parameter int DATA_MEMORY_DEPTH = 256,
  localparam int IDX_W = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DATA_MEMORY_DEPTH];

  // Store port: commits the addressed word on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: RAM plus MMIO (GPIO, optional cycle counter) with
// configurable wait states and a stall back to the pipeline.
// Optional feature: define DBUS_CYCLE_COUNTER_EN to add a free-running
// 32-bit cycle counter readable at MMIO_BASE+4.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          DATA_MEMORY_DEPTH = 256,
  parameter logic [31:0] RAM_BASE          = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE         = 32'h1001_0400,
  parameter int          WAIT_STATES       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Stall_o,
  output logic        Resp_Valid_o,
  output logic        Err_o,
  output logic [31:0] gpio_o
);

  localparam int          IDX_W    = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
  localparam logic [32:0] RAM_SPAN = 33'(4 * DATA_MEMORY_DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] gpio_q;
  logic [31:0] cnt_val;
  logic [31:0] ram_rdata;
  logic [IDX_W-1:0] ram_idx;
  logic        req;
  logic        is_write;
  logic        is_read;
  logic        bad;
  logic        stall;
  logic        resp_cycle;
  logic        commit;
  hit_e        hit;

  // Maps a byte address onto RAM, one of the MMIO registers, or nothing.
  function automatic hit_e decode(input logic [31:0] a);
    logic [32:0] ofs;
    hit_e        res;
    ofs = {1'b0, a} - {1'b0, RAM_BASE};
    res = MISS;
    if (!ofs[32] && (ofs < RAM_SPAN)) begin
      res = HIT_RAM;
    end else if (a == MMIO_BASE + GPIO_OFS) begin
      res = HIT_GPIO;
    end
`ifdef DBUS_CYCLE_COUNTER_EN
    else if (a == MMIO_BASE + CNT_OFS) begin
      res = HIT_CNT;
    end
`endif
    return res;
  endfunction

  // A simultaneous read+write request is handled purely as a write.
  assign req      = Mem_Read_i | Mem_Write_i;
  assign is_write = Mem_Write_i;
  assign is_read  = Mem_Read_i & ~Mem_Write_i;
  assign hit      = decode(Address_i);
  assign ram_idx  = IDX_W'((Address_i - RAM_BASE) >> 2);

  // Misaligned, unmapped, or a store to the read-only counter.
  assign bad = (Address_i[1:0] != 2'b00) || (hit == MISS) ||
               (is_write && (hit == HIT_CNT));

  // State and wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic. The request cycle already counts as one stall cycle,
  // so WAIT lasts WAIT_STATES-1 cycles (minimum one cycle once entered).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall      = 1'b0;
    resp_cycle = 1'b0;
    if (WAIT_STATES == 0) begin
      state_d    = IDLE;
      resp_cycle = req;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            stall      = 1'b1;
            state_d    = WAIT;
            wait_cnt_d = 4'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (wait_cnt_q <= 4'd1) begin
            state_d    = RESP;
            wait_cnt_d = 4'd0;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
        RESP: begin
          resp_cycle = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Reset forces the handshake outputs low immediately, even mid-access.
  assign Stall_o      = stall & ~reset;
  assign Resp_Valid_o = resp_cycle & ~reset;
  assign Err_o        = resp_cycle & bad & ~reset;
  assign commit       = resp_cycle & is_write & ~bad & ~reset;

  // Load data mux; zero outside a good load response.
  always_comb begin
    Read_Data_o = 32'd0;
    if (resp_cycle && !reset && is_read && !bad) begin
      case (hit)
        HIT_RAM:  Read_Data_o = ram_rdata;
        HIT_GPIO: Read_Data_o = gpio_q;
        HIT_CNT:  Read_Data_o = cnt_val;
        default:  Read_Data_o = 32'd0;
      endcase
    end
  end

  dbus_ram_array #(
    .DATA_MEMORY_DEPTH(DATA_MEMORY_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (commit && (hit == HIT_RAM)),
    .idx  (ram_idx),
    .wdata(Write_Data_i),
    .rdata(ram_rdata)
  );

  // GPIO output register, updated on the edge that ends the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q <= 32'd0;
    end else if (commit && (hit == HIT_GPIO)) begin
      gpio_q <= Write_Data_i;
    end
  end

  assign gpio_o = gpio_q;

`ifdef DBUS_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cnt_val = cyc_q;
`else
  assign cnt_val = 32'd0;
`endif

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized self-checking bench for dbus_responder (WAIT_STATES=2).
module tb_dbus_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1001_0400;
  localparam int          DEPTH     = 256;
  localparam int          WS        = 2;
`ifdef DBUS_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Mem_Read_i = 1'b0;
  logic        Mem_Write_i = 1'b0;
  logic [31:0] Address_i = 32'd0;
  logic [31:0] Write_Data_i = 32'd0;
  logic [31:0] Read_Data_o;
  logic        Stall_o;
  logic        Resp_Valid_o;
  logic        Err_o;
  logic [31:0] gpio_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] mem_m [DEPTH];
  logic [31:0] gpio_m = 32'd0;
  logic [31:0] cyc_m;

  dbus_responder #(
    .DATA_MEMORY_DEPTH(DEPTH),
    .RAM_BASE(RAM_BASE),
    .MMIO_BASE(MMIO_BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Mem_Read_i(Mem_Read_i),
    .Mem_Write_i(Mem_Write_i),
    .Address_i(Address_i),
    .Write_Data_i(Write_Data_i),
    .Read_Data_o(Read_Data_o),
    .Stall_o(Stall_o),
    .Resp_Valid_o(Resp_Valid_o),
    .Err_o(Err_o),
    .gpio_o(gpio_o)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release, as the optional counter should read.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc_m <= 32'd0;
    else       cyc_m <= cyc_m + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= RAM_BASE) && (a < RAM_BASE + 4 * DEPTH);
  endfunction

  function automatic bit addr_bad(input logic [31:0] a, input bit wr);
    if (a[1:0] != 2'b00)     return 1'b1;
    if (in_ram(a))           return 1'b0;
    if (a == MMIO_BASE)      return 1'b0;
    if (a == MMIO_BASE + 4)  return CNT_EN ? wr : 1'b1;
    return 1'b1;
  endfunction

  function automatic logic [31:0] read_model(input logic [31:0] a);
    if (in_ram(a))      return mem_m[(a - RAM_BASE) >> 2];
    if (a == MMIO_BASE) return gpio_m;
    return cyc_m;
  endfunction

  // One access from request to the cycle after its response; called at a negedge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] rdata);
    bit          bad;
    bit          got;
    int          stalls;
    logic [31:0] exp_d;
    bad = addr_bad(addr, wr);
    Mem_Read_i   = rd;
    Mem_Write_i  = wr;
    Address_i    = addr;
    Write_Data_i = wdata;
    stalls = 0;
    got    = 1'b0;
    rdata  = 32'd0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (Resp_Valid_o) begin
        got   = 1'b1;
        exp_d = (rd && !wr && !bad) ? read_model(addr) : 32'd0;
        check({tag, ":stall"}, stalls, WS);
        check({tag, ":err"}, {31'd0, Err_o}, {31'd0, bad});
        check({tag, ":data"}, Read_Data_o, exp_d);
        rdata = Read_Data_o;
      end else begin
        if (Stall_o) stalls++;
        @(negedge clk);
      end
    end
    if (!got) check({tag, ":timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    if (got && wr && !bad) begin
      if (in_ram(addr)) mem_m[(addr - RAM_BASE) >> 2] = wdata;
      else if (addr == MMIO_BASE) gpio_m = wdata;
    end
    Mem_Read_i  = 1'b0;
    Mem_Write_i = 1'b0;
    #1;
    check({tag, ":gpio"}, gpio_o, gpio_m);
    check({tag, ":idle"}, {30'd0, Resp_Valid_o, Err_o} | Read_Data_o, 32'd0);
  endtask

  logic [31:0] rv, v1, v2, a;
  int          sel, op;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst:stall", {31'd0, Stall_o}, 32'd0);
    check("rst:valid", {31'd0, Resp_Valid_o}, 32'd0);
    check("rst:err", {31'd0, Err_o}, 32'd0);
    check("rst:rdata", Read_Data_o, 32'd0);
    check("rst:gpio", gpio_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    access(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, "st8", rv);
    access(1, 0, 32'h1001_0008, 32'd0, "ld8", rv);
    check("ld8:val", rv, 32'hDEAD_BEEF);
    access(0, 1, 32'h1001_0400, 32'h0000_0005, "gpio_wr", rv);
    access(1, 0, 32'h1001_0400, 32'd0, "gpio_rd", rv);
    check("gpio_rd:val", rv, 32'h5);
    access(1, 0, 32'h1001_0002, 32'd0, "misal", rv);
    access(1, 0, 32'h1001_2000, 32'd0, "unmap", rv);
    access(0, 1, 32'h1001_2000, 32'h1357_9BDF, "unmap_wr", rv);
    access(1, 1, 32'h1001_0010, 32'h0000_1234, "both", rv);
    access(1, 0, 32'h1001_0010, 32'd0, "both_ld", rv);
    check("both_ld:val", rv, 32'h1234);
    access(1, 0, 32'h1001_0008, 32'd0, "ld8_again", rv);

    // Reset in the middle of a store
    access(0, 1, 32'h1001_0020, 32'h0000_1111, "pre", rv);
    access(0, 1, MMIO_BASE, 32'h0000_0077, "gpio77", rv);
    Mem_Write_i  = 1'b1;
    Address_i    = 32'h1001_0020;
    Write_Data_i = 32'h0000_AAAA;
    #1;
    check("mid:req_stall", {31'd0, Stall_o}, 32'd1);
    @(negedge clk);
    #1;
    check("mid:wait_stall", {31'd0, Stall_o}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid:stall", {31'd0, Stall_o}, 32'd0);
    check("mid:valid", {31'd0, Resp_Valid_o}, 32'd0);
    check("mid:gpio", gpio_o, 32'd0);
    gpio_m = 32'd0;
    Mem_Write_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    access(1, 0, 32'h1001_0020, 32'd0, "post", rv);
    check("post:val", rv, 32'h1111);

    // Cycle counter register
    access(1, 0, MMIO_BASE + 4, 32'd0, "cnt1", v1);
    repeat (10) @(negedge clk);
    access(1, 0, MMIO_BASE + 4, 32'd0, "cnt2", v2);
    access(0, 1, MMIO_BASE + 4, 32'h0000_00FF, "cnt_wr", rv);
`ifdef DBUS_CYCLE_COUNTER_EN
    check("cnt:delta", v2 - v1, 32'd13);
`else
    check("cnt:v1", v1, 32'd0);
    check("cnt:v2", v2, 32'd0);
`endif

    // Randomized traffic over a small working set
    for (int i = 0; i < 16; i++) begin
      access(0, 1, RAM_BASE + 32'(4 * i), $urandom, "init", rv);
    end
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 3);
      case (sel)
        6:       a = MMIO_BASE;
        7:       a = MMIO_BASE + 4;
        8:       a = RAM_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        9:       a = MMIO_BASE + 8 + 32'(4 * $urandom_range(0, 63));
        default: a = RAM_BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      access(op != 1, op == 1 || op == 2, a, $urandom, "rnd", rv);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
